axil_reg_bridge: RTL and testbench

AXI4-Lite slave that converts one AXI transaction at a time into the single-cycle `wen`/`ren` register-access strobes consumed by the clock-generator DRP port. It waits for the completion strobe (`wrdy`/`rrdy`) and returns the AXI response. If the completion strobe never arrives, a timeout returns SLVERR. The block sits directly upstream of the clock generator's register port, between the system interconnect and the MMCM DRP.

---
 rtl/axil_reg_bridge.sv | 178 +++++++++++++++++
 tb/tb_axil_reg_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bridge.sv
// rtl/axil_reg_bridge.sv - AXI4-Lite slave to one-cycle wen/ren register strobe bridge
module axil_reg_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        wen,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic [7:0]  wstrb,
    input  logic        wrdy,
    output logic        ren,
    output logic [31:0] raddr,
    input  logic [31:0] rdata,
    input  logic        rrdy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t        state;
    logic          aw_held;
    logic          w_held;
    logic          last_wr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          in_idle;
    logic          nothing_held;
    logic          tie;
    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;

    // Channel readies: captures only in IDLE; on a read/write tie last_wr picks the winner
    always_comb begin
        in_idle      = (state == IDLE) && !i_reset;
        nothing_held = !aw_held && !w_held;
        tie          = nothing_held && s_arvalid && (s_awvalid || s_wvalid);
        s_awready    = in_idle && !aw_held && !(tie && last_wr);
        s_wready     = in_idle && !w_held && !(tie && last_wr);
        s_arready    = in_idle && nothing_held && !(tie && !last_wr);
        aw_hs        = s_awready && s_awvalid;
        w_hs         = s_wready && s_wvalid;
        ar_hs        = s_arready && s_arvalid;
        cnt_next     = (cnt == TO_LIMIT) ? cnt : cnt + 1'b1;
    end

    // Transaction FSM: capture, one-cycle strobe, bounded wait for completion, hold response
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            last_wr  <= 1'b0;
            cnt      <= '0;
            wen      <= 1'b0;
            ren      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            raddr    <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= '0;
            s_rvalid <= 1'b0;
            s_rresp  <= '0;
            s_rdata  <= '0;
        end else begin
            wen <= 1'b0;
            ren <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        waddr   <= s_awaddr;
                    end
                    if (w_hs) begin
                        w_held <= 1'b1;
                        wdata  <= s_wdata;
                        wstrb  <= {4'b0000, s_wstrb};
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state   <= WR_ISSUE;
                        wen     <= 1'b1;
                        last_wr <= 1'b1;
                    end else if (ar_hs) begin
                        raddr   <= s_araddr;
                        state   <= RD_ISSUE;
                        ren     <= 1'b1;
                        last_wr <= 1'b0;
                    end
                end
                WR_ISSUE: begin
                    cnt   <= '0;
                    state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (wrdy) begin
                        s_bresp  <= RESP_OKAY;
                        s_bvalid <= 1'b1;
                        state    <= WR_RESP;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == TO_LIMIT) begin
                            s_bresp  <= RESP_SLVERR;
                            s_bvalid <= 1'b1;
                            state    <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    cnt   <= '0;
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rrdy) begin
                        s_rdata  <= rdata;
                        s_rresp  <= RESP_OKAY;
                        s_rvalid <= 1'b1;
                        state    <= RD_RESP;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == TO_LIMIT) begin
                            s_rdata  <= '0;
                            s_rresp  <= RESP_SLVERR;
                            s_rvalid <= 1'b1;
                            state    <= RD_RESP;
                        end
                    end
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_bridge.sv
// tb/tb_axil_reg_bridge.sv - bench for axil_reg_bridge with cycle-timestamp reference model
module tb_axil_reg_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wrdy;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        rrdy;

    logic        a_wrdy, man_wrdy, a_rrdy, man_rrdy;
    logic [31:0] a_rdata;
    assign wrdy  = a_wrdy | man_wrdy;
    assign rrdy  = a_rrdy | man_rrdy;
    assign rdata = a_rdata;

    axil_reg_bridge #(.TIMEOUT(T)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wrdy(wrdy),
        .ren(ren), .raddr(raddr), .rdata(rdata), .rrdy(rrdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream register block: answers wen/ren after a programmable delay
    bit          auto_wr = 1'b1;
    bit          auto_rd = 1'b1;
    int          wr_dly = 1;
    int          rd_dly = 1;
    logic [31:0] rd_val = '0;

    initial begin
        a_wrdy  = 1'b0;
        a_rrdy  = 1'b0;
        a_rdata = '0;
        forever begin
            tick();
            if (wen && auto_wr) begin
                repeat (wr_dly) tick();
                a_wrdy = 1'b1;
                tick();
                a_wrdy = 1'b0;
            end else if (ren && auto_rd) begin
                repeat (rd_dly) tick();
                a_rrdy  = 1'b1;
                a_rdata = rd_val;
                tick();
                a_rrdy  = 1'b0;
                a_rdata = '0;
            end
        end
    end

    // Reference model: tracks held channels and strobe/response cycles as timestamps
    int          now;
    int          m_wr_iss = -1;
    int          m_rd_iss = -1;
    bit          m_aw_h, m_w_h, m_last_wr, m_b_on, m_r_on;
    bit          m_idle, m_tie, e_awr, e_wr, e_arr;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic [31:0] m_waddr = '0, m_wdata = '0, m_raddr = '0, m_rdata = '0;
    logic [7:0]  m_wstrb = '0;

    int wen_q[$];
    int ren_q[$];
    int b_hs_n = 0;
    int r_hs_n = 0;
    int overlap_n = 0;
    int last_bhs_cyc = 0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            now    = cyc;
            m_idle = (m_wr_iss < 0) && (m_rd_iss < 0) && !i_reset;
            m_tie  = !m_aw_h && !m_w_h && s_arvalid && (s_awvalid || s_wvalid);
            e_awr  = m_idle && !m_aw_h && !(m_tie && m_last_wr);
            e_wr   = m_idle && !m_w_h && !(m_tie && m_last_wr);
            e_arr  = m_idle && !m_aw_h && !m_w_h && !(m_tie && !m_last_wr);

            chk("ready", {s_awready, s_wready, s_arready}, {e_awr, e_wr, e_arr});
            chk("strobe", {wen, ren}, {now == m_wr_iss, now == m_rd_iss});
            chk("valid", {s_bvalid, s_rvalid}, {m_b_on, m_r_on});
            if (m_b_on) chk("bresp", s_bresp, m_bresp);
            if (m_r_on) chk("rresp_rdata", {s_rresp, s_rdata}, {m_rresp, m_rdata});
            chk("waddr", waddr, m_waddr);
            chk("wdata", wdata, m_wdata);
            chk("wstrb", wstrb, m_wstrb);
            chk("raddr", raddr, m_raddr);

            if (wen) wen_q.push_back(cyc);
            if (ren) ren_q.push_back(cyc);
            if (wen && ren) overlap_n++;
            if (s_bvalid && s_bready) begin
                b_hs_n++;
                last_bhs_cyc = cyc;
            end
            if (s_rvalid && s_rready) r_hs_n++;

            if (i_reset) begin
                m_aw_h = 0; m_w_h = 0; m_last_wr = 0; m_b_on = 0; m_r_on = 0;
                m_wr_iss = -1; m_rd_iss = -1;
                m_bresp = '0; m_rresp = '0; m_rdata = '0;
                m_waddr = '0; m_wdata = '0; m_wstrb = '0; m_raddr = '0;
            end else begin
                if (m_b_on && s_bready) begin
                    m_b_on = 0; m_aw_h = 0; m_w_h = 0; m_wr_iss = -1;
                end
                if (m_r_on && s_rready) begin
                    m_r_on = 0; m_rd_iss = -1;
                end
                if (m_wr_iss >= 0 && !m_b_on && now > m_wr_iss && now <= m_wr_iss + T) begin
                    if (wrdy) begin
                        m_b_on = 1; m_bresp = 2'b00;
                    end else if (now == m_wr_iss + T) begin
                        m_b_on = 1; m_bresp = 2'b10;
                    end
                end
                if (m_rd_iss >= 0 && !m_r_on && now > m_rd_iss && now <= m_rd_iss + T) begin
                    if (rrdy) begin
                        m_r_on = 1; m_rresp = 2'b00; m_rdata = rdata;
                    end else if (now == m_rd_iss + T) begin
                        m_r_on = 1; m_rresp = 2'b10; m_rdata = '0;
                    end
                end
                if (e_awr && s_awvalid) begin
                    m_aw_h = 1; m_waddr = s_awaddr;
                end
                if (e_wr && s_wvalid) begin
                    m_w_h = 1; m_wdata = s_wdata; m_wstrb = {4'b0000, s_wstrb};
                end
                if (e_arr && s_arvalid) begin
                    m_rd_iss = now + 1; m_raddr = s_araddr; m_last_wr = 0;
                end
                if (m_aw_h && m_w_h && m_wr_iss < 0) begin
                    m_wr_iss = now + 1; m_last_wr = 1;
                end
            end
        end
    end

    task automatic clr_mon();
        wen_q.delete();
        ren_q.delete();
        b_hs_n = 0;
        r_hs_n = 0;
    endtask

    // Present any subset of AW/W/AR and hold each valid until its own handshake
    task automatic do_xfer(input bit use_aw, input bit use_w, input bit use_ar,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] ra);
        bit aw_p, w_p, ar_p, aw_d, w_d, ar_d;
        int k;
        aw_p = use_aw; w_p = use_w; ar_p = use_ar;
        if (use_aw) begin s_awaddr = a; s_awvalid = 1'b1; end
        if (use_w)  begin s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; end
        if (use_ar) begin s_araddr = ra; s_arvalid = 1'b1; end
        k = 0;
        while ((aw_p || w_p || ar_p) && k < 200) begin
            @(negedge clk);
            aw_d = aw_p && s_awready;
            w_d  = w_p && s_wready;
            ar_d = ar_p && s_arready;
            tick();
            if (aw_d) begin aw_p = 0; s_awvalid = 1'b0; end
            if (w_d)  begin w_p = 0; s_wvalid = 1'b0; end
            if (ar_d) begin ar_p = 0; s_arvalid = 1'b0; end
            k++;
        end
        chk("handshake_done", {aw_p, w_p, ar_p}, 3'b000);
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0:       return wen;
            1:       return ren;
            2:       return s_bvalid;
            default: return s_rvalid;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name, output int at);
        int k = 0;
        while (!sig_of(which) && k < 40) begin
            tick();
            k++;
        end
        chk({name, "_seen"}, sig_of(which), 1'b1);
        at = cyc;
    endtask

    int w_at, r_at, b_at, v_at;

    initial begin
        i_reset = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 1'b1; s_araddr = '0; s_arvalid = 0; s_rready = 1'b1;
        man_wrdy = 0; man_rrdy = 0;
        repeat (3) tick();
        chk("rst_ctrl", {s_awready, s_wready, s_arready, wen, ren, s_bvalid, s_rvalid}, 7'd0);
        chk("rst_resp", {s_bresp, s_rresp, s_rdata}, 36'd0);
        chk("rst_regs", {waddr, wstrb, raddr}, 72'd0);
        i_reset = 1'b0;
        tick();

        // single write, wrdy two cycles after wen
        clr_mon();
        wr_dly = 2;
        do_xfer(1, 1, 0, 32'h0000_0008, 32'h0000_1234, 4'hF, '0);
        wait_for(0, "s1_wen", w_at);
        wait_for(2, "s1_bvalid", b_at);
        chk("s1_b_latency", b_at - w_at, 3);
        chk("s1_bresp", s_bresp, 2'b00);
        chk("s1_waddr", waddr[10:0], 11'h008);
        chk("s1_wstrb", wstrb, 8'h0F);
        repeat (4) tick();
        chk("s1_wen_count", wen_q.size(), 1);

        // read with rrdy four cycles after ren and three cycles of backpressure
        clr_mon();
        rd_dly = 4; rd_val = 32'h0000_ABCD; s_rready = 1'b0;
        do_xfer(0, 0, 1, '0, '0, '0, 32'h0000_0016);
        wait_for(1, "s2_ren", r_at);
        wait_for(3, "s2_rvalid", v_at);
        chk("s2_r_latency", v_at - r_at, 5);
        chk("s2_rdata", s_rdata, 32'h0000_ABCD);
        chk("s2_rresp", s_rresp, 2'b00);
        chk("s2_raddr", raddr, 32'h0000_0016);
        tick();
        chk("s2_hold1", s_rvalid, 1'b1);
        tick();
        chk("s2_hold2", s_rvalid, 1'b1);
        tick();
        s_rready = 1'b1;
        tick();
        chk("s2_released", s_rvalid, 1'b0);

        // W five cycles ahead of AW while a read waits
        clr_mon();
        wr_dly = 1; rd_dly = 1; rd_val = 32'h5555_0001;
        fork
            begin
                do_xfer(0, 1, 0, '0, 32'hCAFE_0003, 4'h3, '0);
                repeat (4) tick();
                do_xfer(1, 0, 0, 32'h0000_0020, '0, '0, '0);
            end
            do_xfer(0, 0, 1, '0, '0, '0, 32'h0000_0040);
        join
        wait_for(1, "s3_ren", r_at);
        chk("s3_read_after_b", r_at - last_bhs_cyc, 2);
        wait_for(3, "s3_rvalid", v_at);
        chk("s3_rdata", s_rdata, 32'h5555_0001);
        repeat (3) tick();

        // simultaneous AW+W+AR from reset, then a second tie
        i_reset = 1'b1;
        repeat (2) tick();
        i_reset = 1'b0;
        clr_mon();
        fork
            begin
                do_xfer(1, 1, 0, 32'h0000_0030, 32'h1111_2222, 4'hF, '0);
                do_xfer(1, 1, 0, 32'h0000_0034, 32'h3333_4444, 4'h1, '0);
            end
            do_xfer(0, 0, 1, '0, '0, '0, 32'h0000_0038);
        join
        repeat (12) tick();
        chk("s4_counts", {wen_q.size(), ren_q.size()}, {32'd2, 32'd1});
        if (wen_q.size() == 2 && ren_q.size() == 1) begin
            chk("s4_write_first", wen_q[0] < ren_q[0], 1'b1);
            chk("s4_read_second_tie", ren_q[0] < wen_q[1], 1'b1);
        end

        // write timeout then a late wrdy
        clr_mon();
        auto_wr = 1'b0;
        do_xfer(1, 1, 0, 32'h0000_0044, 32'h0BAD_F00D, 4'hC, '0);
        wait_for(0, "s5_wen", w_at);
        wait_for(2, "s5_bvalid", b_at);
        chk("s5_timeout_cycle", b_at - w_at, T + 1);
        chk("s5_bresp", s_bresp, 2'b10);
        repeat (3) tick();
        man_wrdy = 1'b1;
        tick();
        man_wrdy = 1'b0;
        repeat (10) tick();
        chk("s5_one_resp", b_hs_n, 1);
        auto_wr = 1'b1;

        // reset during RD_WAIT, then a stale rrdy
        clr_mon();
        auto_rd = 1'b0;
        do_xfer(0, 0, 1, '0, '0, '0, 32'h0000_0050);
        wait_for(1, "s6_ren", r_at);
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
        chk("s6_rst_outputs", {s_arready, ren, s_rvalid, raddr}, 35'd0);
        i_reset = 1'b0;
        repeat (2) tick();
        man_rrdy = 1'b1;
        tick();
        man_rrdy = 1'b0;
        repeat (10) tick();
        chk("s6_no_resp", r_hs_n, 0);
        auto_rd = 1'b1;

        chk("wen_ren_overlap", overlap_n, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
